// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception responder: SR/Cause/EPC/PRId, same-cycle Req, eret support.
// Optional Count/Compare timer interrupt enabled by defining CP0_COUNT_EN.
module cp0_exc_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0007
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] CP0In,
  input  logic        en,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic [5:0]  w_hwint;
  logic        w_ti;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_wr;
  logic [31:0] w_victim;

  // A taken exception discards any mtc0 in the same cycle.
  assign w_wr = en & ~Req;

`ifdef CP0_COUNT_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr && A2 == 5'd9) r_count <= CP0In;
      else                    r_count <= r_count + 32'd1;
      if (w_wr && A2 == 5'd11) begin
        r_compare <= CP0In;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign w_ti = r_ti;
`else
  assign w_ti = 1'b0;
`endif

  // Timer interrupt shares hardware line 5.
  assign w_hwint   = HWInt | {w_ti, 5'b0};
  assign w_int_req = (|(w_hwint & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_sr_exl;
  assign Req       = w_int_req | w_exc_req;
  assign w_victim  = BDIn ? (VPC - 32'd4) : VPC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr_im     <= 6'd0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= 6'd0;
      r_cause_exc <= 5'd0;
      r_epc       <= 32'd0;
    end else begin
      r_cause_ip <= w_hwint;
      if (Req) begin
        r_sr_exl    <= 1'b1;
        r_cause_exc <= w_int_req ? 5'd0 : ExcCodeIn;
        r_cause_bd  <= BDIn;
        r_epc       <= {w_victim[31:2], 2'b00};
      end else begin
        if (w_wr && A2 == 5'd12) begin
          r_sr_im  <= CP0In[15:10];
          r_sr_exl <= CP0In[1];
          r_sr_ie  <= CP0In[0];
        end
        // eret overrides an mtc0 SR write for the EXL bit only.
        if (EXLClr) r_sr_exl <= 1'b0;
        if (w_wr && A2 == 5'd14) r_epc <= {CP0In[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    CP0Out = 32'd0;
    case (A1)
      5'd12: CP0Out = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
      5'd13: CP0Out = {r_cause_bd, w_ti, 14'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};
      5'd14: CP0Out = r_epc;
      5'd15: CP0Out = PRID_VALUE;
`ifdef CP0_COUNT_EN
      5'd9:  CP0Out = r_count;
      5'd11: CP0Out = r_compare;
`endif
      default: CP0Out = 32'd0;
    endcase
  end

  assign EPCOut = r_epc;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit; timer vectors run only when CP0_COUNT_EN is defined.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset_n;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] CP0In;
  logic        en;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int total;
  int bad;

  cp0_exc_unit #(.PRID_VALUE(32'h0000_0007)) dut (
    .clk(clk), .reset_n(reset_n), .A1(A1), .A2(A2), .CP0In(CP0In), .en(en),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    chk(tag, CP0Out, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; A2 = a; CP0In = d;
    tick();
    en = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; A1 = 5'd0; A2 = 5'd0; CP0In = 32'd0; en = 1'b0;
    VPC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    #12;
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    rd("prid", 5'd15, 32'h0000_0007);
    chk("rst_epcout", EPCOut, 32'd0);
    chk("rst_req", {31'd0, Req}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Overflow exception
    ExcCodeIn = 5'd12; VPC = 32'h3010; BDIn = 1'b0;
    #1;
    chk("ov_req", {31'd0, Req}, 32'd1);
    tick();
    rd("ov_cause", 5'd13, 32'h0000_0030);
    rd("ov_epc", 5'd14, 32'h3010);
    rd("ov_sr", 5'd12, 32'h2);
    chk("ov_req_exl", {31'd0, Req}, 32'd0);
    ExcCodeIn = 5'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd("eret_sr", 5'd12, 32'h0);

    // Exception in a delay slot
    ExcCodeIn = 5'd4; VPC = 32'h3024; BDIn = 1'b1;
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    rd("bd_epc", 5'd14, 32'h3020);
    rd("bd_cause", 5'd13, 32'h8000_0010);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

    // Interrupt beats a simultaneous exception
    mtc0(5'd12, 32'h0000_0401);
    rd("int_sr", 5'd12, 32'h0000_0401);
    HWInt = 6'b000001; ExcCodeIn = 5'd5; VPC = 32'h3040;
    #1;
    chk("int_req", {31'd0, Req}, 32'd1);
    tick();
    ExcCodeIn = 5'd0;
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr_exl", 5'd12, 32'h0000_0403);
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    mtc0(5'd12, 32'h0000_0400);
    HWInt = 6'b000001;
    #1;
    chk("int_ie0_req", {31'd0, Req}, 32'd0);
    tick();
    rd("int_ie0_ip", 5'd13, 32'h0000_0400);
    HWInt = 6'd0;

    // mtc0 EPC discarded while Req is high
    en = 1'b1; A2 = 5'd14; CP0In = 32'h5555; ExcCodeIn = 5'd12; VPC = 32'h3050;
    tick();
    en = 1'b0; ExcCodeIn = 5'd0;
    chk("mtc0_req_epc", EPCOut, 32'h3050);
    rd("mtc0_req_cause", 5'd13, 32'h0000_0030);
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd("eret2_sr", 5'd12, 32'h0000_0400);
    chk("eret2_epc", EPCOut, 32'h3050);

    // Plain mtc0 EPC, not visible until the next cycle
    en = 1'b1; A2 = 5'd14; CP0In = 32'h5557;
    #1;
    chk("no_bypass", EPCOut, 32'h3050);
    tick();
    en = 1'b0;
    chk("mtc0_epc", EPCOut, 32'h5554);

    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h0000_0030);
    mtc0(5'd15, 32'hFFFF_FFFF);
    rd("prid_ro", 5'd15, 32'h0000_0007);
`ifndef CP0_COUNT_EN
    mtc0(5'd9, 32'h1234_5678);
    rd("undef9", 5'd9, 32'd0);
    rd("undef11", 5'd11, 32'd0);
`endif

    // mtc0 SR together with eret: EXL cleared, IM/IE written
    ExcCodeIn = 5'd12; VPC = 32'h3060;
    tick();
    ExcCodeIn = 5'd0;
    rd("exl_set", 5'd12, 32'h0000_0402);
    en = 1'b1; A2 = 5'd12; CP0In = 32'h0000_0C03; EXLClr = 1'b1;
    tick();
    en = 1'b0; EXLClr = 1'b0;
    rd("sr_eret_mix", 5'd12, 32'h0000_0C01);

    // Asynchronous reset mid-cycle
    mtc0(5'd14, 32'h3000);
    chk("pre_rst_epc", EPCOut, 32'h3000);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_epc", EPCOut, 32'd0);
    rd("arst_sr", 5'd12, 32'd0);
    rd("arst_cause", 5'd13, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

`ifdef CP0_COUNT_EN
    begin
      int n;
      mtc0(5'd11, 32'd10);
      mtc0(5'd9, 32'd0);
      mtc0(5'd12, 32'h0000_8001);
      #1;
      chk("cnt_early_req", {31'd0, Req}, 32'd0);
      n = 0;
      while (!Req && n < 40) begin
        tick();
        n++;
      end
      chk("cnt_req", {31'd0, Req}, 32'd1);
      tick();
      rd("cnt_ti", 5'd13, 32'h4000_8000);
      mtc0(5'd11, 32'd100000);
      rd("cnt_ti_clr", 5'd13, 32'h0000_8000);
      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
      chk("cnt_req_drop", {31'd0, Req}, 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
